// File: rtl/uart_pkg.sv
// Shared types and constants for the bit-clock UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STOP  = 2'd2,
    ST_BREAK = 2'd3
  } rx_state_e;

  localparam int         DATA_BITS  = 8;
  localparam logic       IDLE_LEVEL = 1'b1;
  localparam logic [7:0] PAT_FIRST  = 8'h41;  // 'A'
  localparam logic [7:0] PAT_LAST   = 8'h46;  // 'F'

  // Pattern byte expected after b; anything outside the pattern restarts it.
  function automatic logic [7:0] next_expected(input logic [7:0] b,
                                               input logic [7:0] first,
                                               input logic [7:0] last);
    if (b == last) return first;
    else if ((b >= first) && (b < last)) return b + 8'd1;
    else return first;
  endfunction

  // Increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small byte FIFO with registered head outputs and drop-on-full reporting.
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_inside,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       drop
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        empty, full, do_push, do_pop;

  // Pointer update and next head selection, with bypass of a byte written this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_d        = wr_q;
    rd_d        = rd_q;
    out_data_d  = out_data_q;
    empty       = (wr_q == rd_q);
    full        = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    do_pop      = pop && !empty;
    do_push     = push && (!full || do_pop);
    drop        = push && full && !do_pop;
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
    out_valid_d = (wr_d != rd_d);
    if (out_valid_d) begin
      if (rd_d == wr_q) out_data_d = push_data;
      else              out_data_d = mem[rd_d[AW-1:0]];
    end
  end

  // Storage array.
  // NOTE: the data array has no reset; only pointers and registered outputs need one.
  always_ff @(posedge clk_inside) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_data;
  end

  // Pointers and registered head.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_inside or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/uart_rx_bitclk.sv
// 1x-sampled 8N1 receiver with byte FIFO and A..F pattern checker.
module uart_rx_bitclk
  import uart_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SEQ_FIRST   = PAT_FIRST,
  parameter logic [7:0] SEQ_LAST    = PAT_LAST
) (
  input  logic       clk_inside,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic [7:0] seq_ok_cnt,
  output logic [7:0] seq_err_cnt,
  output logic       busy
);

  localparam int                 BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             seq_ok_q, seq_ok_d;
  logic [7:0]             seq_err_q, seq_err_d;
  logic [7:0]             expected_q, expected_d;
  logic                   rx_s, good_byte, fifo_drop;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Synchronizer shift, deframing FSM and pattern checker next-state logic.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    frame_err_d = 1'b0;
    seq_ok_d    = seq_ok_q;
    seq_err_d   = seq_err_q;
    expected_d  = expected_q;
    good_byte   = 1'b0;
    overflow_d  = overflow_q | fifo_drop;

    case (state_q)
      ST_IDLE: begin
        if (rx_s != IDLE_LEVEL) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (rx_s == IDLE_LEVEL) begin
          good_byte = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_BREAK;
        end
      end
      ST_BREAK: begin
        // Stay here while the line is held low so a break never looks like a start bit.
        if (rx_s == IDLE_LEVEL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Checker sees every good byte, even one the FIFO has to drop.
    if (good_byte) begin
      if (shreg_q == expected_q) seq_ok_d  = sat_inc(seq_ok_q);
      else                       seq_err_d = sat_inc(seq_err_q);
      expected_d = next_expected(shreg_q, SEQ_FIRST, SEQ_LAST);
    end
  end

  // All receiver state, asynchronously reset.
  always_ff @(posedge clk_inside or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      seq_ok_q    <= '0;
      seq_err_q   <= '0;
      expected_q  <= SEQ_FIRST;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      seq_ok_q    <= seq_ok_d;
      seq_err_q   <= seq_err_d;
      expected_q  <= expected_d;
    end
  end

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_inside (clk_inside),
    .rst_n      (rst_n),
    .push       (good_byte),
    .push_data  (shreg_q),
    .pop        (out_valid && out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .drop       (fifo_drop)
  );

  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign seq_ok_cnt  = seq_ok_q;
  assign seq_err_cnt = seq_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_bitclk.sv
// Scoreboard bench for uart_rx_bitclk: directed frames, queued expected bytes.
module tb_uart_rx_bitclk;

  logic       clk_inside = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       overflow;
  logic [7:0] seq_ok_cnt;
  logic [7:0] seq_err_cnt;
  logic       busy;

  int         checks    = 0;
  int         errors    = 0;
  int         fe_cycles = 0;
  logic [7:0] exp_q [$];

  always #5 clk_inside = ~clk_inside;

  uart_rx_bitclk dut (
    .clk_inside  (clk_inside),
    .rst_n       (rst_n),
    .rx_in       (rx_in),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .seq_ok_cnt  (seq_ok_cnt),
    .seq_err_cnt (seq_err_cnt),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: counts frame_err cycles and checks every byte handed out.
  always @(negedge clk_inside) begin
    if (rst_n === 1'b1) begin
      if (frame_err === 1'b1) fe_cycles++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%0h expected=none", out_data);
        end else begin
          check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_inside);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, then the given stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_in = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick();
    end
    rx_in = stop_bit;
    tick();
  endtask

  task automatic do_reset();
    rx_in     = 1'b1;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] stream [12] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                              8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
  logic [7:0] mix    [4]  = '{8'h41, 8'h42, 8'h58, 8'h44};
  logic [7:0] fill   [5]  = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
  int         fe_base;

  initial begin
    rst_n     = 1'b1;
    rx_in     = 1'b1;
    out_ready = 1'b0;
    #1 rst_n  = 1'b0;
    #1;
    // Asynchronous reset state, before any clock edge.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_seq_ok", 32'(seq_ok_cnt), 32'd0);
    check("rst_seq_err", 32'(seq_err_cnt), 32'd0);
    do_reset();

    // Idle line for 50 cycles.
    fe_base = fe_cycles;
    repeat (50) tick();
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_frame_err", 32'(fe_cycles - fe_base), 32'd0);
    check("idle_seq_ok", 32'(seq_ok_cnt), 32'd0);
    check("idle_seq_err", 32'(seq_err_cnt), 32'd0);

    // Single 'A': out_valid must rise exactly after edge 12.
    send_frame(8'h41, 1'b1);
    rx_in = 1'b1;
    tick();
    check("a_valid_edge11", 32'(out_valid), 32'd0);
    tick();
    check("a_valid_edge12", 32'(out_valid), 32'd1);
    check("a_data", 32'(out_data), 32'h41);
    check("a_seq_ok", 32'(seq_ok_cnt), 32'd1);
    exp_q.push_back(8'h41);
    out_ready = 1'b1;
    wait_drain("a_drain");
    do_reset();

    // Back-to-back A..F twice, no idle between frames.
    out_ready = 1'b1;
    foreach (stream[i]) begin
      exp_q.push_back(stream[i]);
      send_frame(stream[i], 1'b1);
    end
    rx_in = 1'b1;
    repeat (3) tick();
    check("stream_seq_ok", 32'(seq_ok_cnt), 32'd12);
    check("stream_seq_err", 32'(seq_err_cnt), 32'd0);
    wait_drain("stream_drain");
    do_reset();

    // A,B,X,D: X mismatches, D mismatches against restarted 'A'; checker then expects 'E'.
    out_ready = 1'b1;
    foreach (mix[i]) begin
      exp_q.push_back(mix[i]);
      send_frame(mix[i], 1'b1);
    end
    rx_in = 1'b1;
    repeat (3) tick();
    check("mix_seq_ok", 32'(seq_ok_cnt), 32'd2);
    check("mix_seq_err", 32'(seq_err_cnt), 32'd2);
    exp_q.push_back(8'h45);
    send_frame(8'h45, 1'b1);
    rx_in = 1'b1;
    repeat (3) tick();
    check("resync_seq_ok", 32'(seq_ok_cnt), 32'd3);
    check("resync_seq_err", 32'(seq_err_cnt), 32'd2);
    wait_drain("mix_drain");
    do_reset();

    // 'C' with a low stop bit, line held low: one frame_err cycle, no byte, no retrigger.
    out_ready = 1'b1;
    fe_base   = fe_cycles;
    send_frame(8'h43, 1'b0);
    rx_in = 1'b0;
    repeat (20) tick();
    check("brk_fe_cycles", 32'(fe_cycles - fe_base), 32'd1);
    check("brk_no_push", 32'(out_valid), 32'd0);
    check("brk_seq_ok", 32'(seq_ok_cnt), 32'd0);
    check("brk_seq_err", 32'(seq_err_cnt), 32'd0);
    rx_in = 1'b1;
    repeat (3) tick();
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b1);
    rx_in = 1'b1;
    repeat (3) tick();
    check("brk_d_seq_err", 32'(seq_err_cnt), 32'd1);
    check("brk_fe_after", 32'(fe_cycles - fe_base), 32'd1);
    wait_drain("brk_drain");
    do_reset();

    // Fill with out_ready low: 'E' is dropped but still counted as a pattern match.
    foreach (fill[i]) begin
      if (i < 4) exp_q.push_back(fill[i]);
      send_frame(fill[i], 1'b1);
    end
    rx_in = 1'b1;
    tick();
    tick();
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_head", 32'(out_data), 32'h41);
    check("fill_seq_ok", 32'(seq_ok_cnt), 32'd5);
    // 'F' arrives while full; a pop on the same edge makes room.
    exp_q.push_back(8'h46);
    send_frame(8'h46, 1'b1);
    rx_in = 1'b1;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("same_cycle_overflow", 32'(overflow), 32'd1);
    check("same_cycle_head", 32'(out_data), 32'h42);
    check("same_cycle_seq_ok", 32'(seq_ok_cnt), 32'd6);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("part_drain_left", 32'(exp_q.size()), 32'd2);

    // Reset mid-DATA with bytes buffered and overflow set.
    rx_in = 1'b0;
    repeat (5) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    rx_in = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
    check("mid_rst_seq_ok", 32'(seq_ok_cnt), 32'd0);
    check("mid_rst_seq_err", 32'(seq_err_cnt), 32'd0);
    exp_q.delete();
    tick();
    rst_n   = 1'b1;
    fe_base = fe_cycles;
    repeat (15) tick();
    check("post_rst_no_frame_err", 32'(fe_cycles - fe_base), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
